// File: rtl/scalar_bitcnt_unit_pkg.sv
// Shared opcode constants and count-width helper for the scalar bit-count unit.
package scalar_bitcnt_unit_pkg;

  localparam logic [6:0] OP_POP = 7'o026;
  localparam logic [6:0] OP_LZ  = 7'o027;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/scalar_bitcnt_unit_lzc8.sv
// 8-bit leading-zero counter: zero_bar flags any set bit, cnt is the number of 0s above the top 1.
module bitcnt_lzc8 (
  input  logic [7:0] d,
  output logic       zero_bar,
  output logic [2:0] cnt
);

  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    zero_bar = |d;
    cnt      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) cnt = 3'(7 - i);
    end
  end

endmodule

// File: rtl/scalar_bitcnt_unit.sv
// Scalar pop-count / leading-zero-count unit delivering a zero-extended count to the A-register port.
// Defining SCALAR_BITCNT_TZ_EN adds the trailing-zero opcode TZ_OPCODE on the shared LZ tree.
module scalar_bitcnt_unit
  import scalar_bitcnt_unit_pkg::*;
#(
  parameter int         DATA_W    = 64,
  parameter int         RES_W     = 24,
  parameter int         POP_LAT   = 4,
  parameter int         LZ_LAT    = 3,
  parameter logic [6:0] TZ_OPCODE = 7'b1111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [6:0]        i_instr,
  input  logic [2:0]        i_i,
  input  logic [DATA_W-1:0] i_sj,
  output logic              o_ready,
  output logic              o_valid,
  output logic [2:0]        o_dest,
  output logic [RES_W-1:0]  o_result,
  output logic              o_collision
);

  localparam int CNT_W  = cnt_w(DATA_W);
  localparam int SLOT_W = (POP_LAT > LZ_LAT) ? POP_LAT : LZ_LAT;
  localparam int NB     = DATA_W / 8;
  localparam int NS     = POP_LAT - 1;
  localparam int LV     = $clog2(DATA_W);

  typedef logic [DATA_W-1:0][CNT_W-1:0] pop_arr_t;

  // Issue handshake: an instruction is taken when i_valid, a recognised opcode and o_ready are all
  // high at the clock edge. A recognised issue seen with o_ready low is dropped (never stalled) and
  // reported on o_collision in the following cycle; unrecognised opcodes always see o_ready high.
  logic              is_pop, is_lzt, recog, busy, accept, reject;
  logic [SLOT_W-1:0] slot, slot_set;
`ifdef SCALAR_BITCNT_TZ_EN
  logic              is_tz;
  assign is_tz = (i_instr == TZ_OPCODE);
`endif

  always_comb begin
    is_pop = (i_instr == OP_POP);
    is_lzt = (i_instr == OP_LZ);
`ifdef SCALAR_BITCNT_TZ_EN
    is_lzt = is_lzt | is_tz;
`endif
    recog    = is_pop | is_lzt;
    busy     = is_pop ? slot[POP_LAT-1] : slot[LZ_LAT-1];
    o_ready  = ~recog | ~busy;
    accept   = i_valid & recog & ~busy;
    reject   = i_valid & recog & busy;
    slot_set = '0;
    if (accept) begin
      if (is_pop) slot_set[POP_LAT-1] = 1'b1;
      else        slot_set[LZ_LAT-1]  = 1'b1;
    end
  end

  // Bit k of slot: the write port is taken by a result retiring k+1 cycles from now.
  always_ff @(posedge clk) begin
    if (rst) slot <= '0;
    else     slot <= (slot | slot_set) >> 1;
  end

  // ---------------- pop-count pipeline ----------------
  function automatic pop_arr_t pop_reduce(input pop_arr_t a, input int lf, input int lt);
    pop_arr_t r;
    int       n;
    r = a;
    n = DATA_W;
    for (int l = 0; l < LV; l++) begin
      if (l >= lf && l < lt) begin
        for (int i = 0; i < DATA_W / 2; i++) begin
          if (2 * i + 1 < n)  r[i] = r[2*i] + r[2*i+1];
          else if (2 * i < n) r[i] = r[2*i];
          else                r[i] = '0;
        end
        for (int i = DATA_W / 2; i < DATA_W; i++) r[i] = '0;
      end
      n = (n + 1) / 2;
    end
    return r;
  endfunction

  pop_arr_t        pop_in;
  pop_arr_t        pop_a [NS];
  logic [2:0]      pop_d [NS];
  logic [NS-1:0]   pop_v;

  always_comb begin
    for (int i = 0; i < DATA_W; i++) pop_in[i] = {{(CNT_W-1){1'b0}}, i_sj[i]};
  end

  // Tree levels are spread evenly over the NS stage registers.
  always_ff @(posedge clk) begin
    pop_a[0] <= pop_reduce(pop_in, 0, LV / NS);
    pop_d[0] <= i_i;
    for (int s = 1; s < NS; s++) begin
      pop_a[s] <= pop_reduce(pop_a[s-1], s * LV / NS, (s + 1) * LV / NS);
      pop_d[s] <= pop_d[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pop_v <= '0;
    else begin
      pop_v[0] <= accept & is_pop;
      for (int s = 1; s < NS; s++) pop_v[s] <= pop_v[s-1];
    end
  end

  // ---------------- leading/trailing-zero pipeline ----------------
  logic [DATA_W-1:0] lz_op;
  logic [NB-1:0]     byte_zb, lz1_zb;
  logic [2:0]        byte_cnt [NB];
  logic [2:0]        lz1_cnt [NB];
  logic [2:0]        lz1_d;
  logic              lz1_v;

`ifdef SCALAR_BITCNT_TZ_EN
  always_comb begin
    for (int b = 0; b < DATA_W; b++) lz_op[b] = is_tz ? i_sj[DATA_W-1-b] : i_sj[b];
  end
`else
  assign lz_op = i_sj;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_byte
    bitcnt_lzc8 u_lzc8 (.d(lz_op[8*b +: 8]), .zero_bar(byte_zb[b]), .cnt(byte_cnt[b]));
  end

  always_ff @(posedge clk) begin
    lz1_zb  <= byte_zb;
    lz1_cnt <= byte_cnt;
    lz1_d   <= i_i;
  end

  always_ff @(posedge clk) begin
    if (rst) lz1_v <= 1'b0;
    else     lz1_v <= accept & is_lzt;
  end

  // Top byte sits at the encoder's MSB so its count is the index of the first non-zero byte.
  logic [7:0]       enc_in;
  logic             enc_zb;
  logic [2:0]       enc_cnt, sel;
  logic [CNT_W-1:0] lz2_cnt;

  always_comb begin
    enc_in = '0;
    for (int b = 0; b < NB; b++) enc_in[8-NB+b] = lz1_zb[b];
  end

  bitcnt_lzc8 u_enc (.d(enc_in), .zero_bar(enc_zb), .cnt(enc_cnt));

  always_comb begin
    sel = 3'(NB - 1) - enc_cnt;
    if (!enc_zb) lz2_cnt = CNT_W'(DATA_W);
    else         lz2_cnt = CNT_W'({enc_cnt, lz1_cnt[sel]});
  end

  logic             lz_last_v;
  logic [2:0]       lz_last_d;
  logic [CNT_W-1:0] lz_last_c;

  if (LZ_LAT == 2) begin : g_lz_direct
    assign lz_last_v = lz1_v;
    assign lz_last_d = lz1_d;
    assign lz_last_c = lz2_cnt;
  end else begin : g_lz_delay
    localparam int LD = LZ_LAT - 2;
    logic [LD-1:0]    dv;
    logic [2:0]       dd [LD];
    logic [CNT_W-1:0] dc [LD];

    always_ff @(posedge clk) begin
      dd[0] <= lz1_d;
      dc[0] <= lz2_cnt;
      for (int s = 1; s < LD; s++) begin
        dd[s] <= dd[s-1];
        dc[s] <= dc[s-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) dv <= '0;
      else begin
        dv[0] <= lz1_v;
        for (int s = 1; s < LD; s++) dv[s] <= dv[s-1];
      end
    end

    assign lz_last_v = dv[LD-1];
    assign lz_last_d = dd[LD-1];
    assign lz_last_c = dc[LD-1];
  end

  // ---------------- write-port output register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_dest      <= '0;
      o_result    <= '0;
      o_collision <= 1'b0;
    end else begin
      o_collision <= reject;
      o_valid     <= pop_v[NS-1] | lz_last_v;
      if (pop_v[NS-1]) begin
        o_dest   <= pop_d[NS-1];
        o_result <= RES_W'(pop_a[NS-1][0]);
      end else if (lz_last_v) begin
        o_dest   <= lz_last_d;
        o_result <= RES_W'(lz_last_c);
      end else begin
        o_dest   <= '0;
        o_result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scalar_bitcnt_unit.sv
// Self-checking bench for scalar_bitcnt_unit: directed scenarios plus randomized issue traffic.
module tb_scalar_bitcnt_unit;

  localparam int DATA_W  = 64;
  localparam int RES_W   = 24;
  localparam int POP_LAT = 4;
  localparam int LZ_LAT  = 3;
  localparam logic [6:0] OP_POP = 7'o026;
  localparam logic [6:0] OP_LZ  = 7'o027;
  localparam logic [6:0] OP_TZ  = 7'b1111111;
`ifdef SCALAR_BITCNT_TZ_EN
  localparam bit TZ_EN = 1'b1;
`else
  localparam bit TZ_EN = 1'b0;
`endif
  localparam int EW = 32 + 3 + RES_W;

  typedef struct packed {
    logic              r;
    logic              v;
    logic [6:0]        op;
    logic [2:0]        d;
    logic [DATA_W-1:0] sj;
  } stim_t;

  logic              clk, rst, i_valid, o_ready, o_valid, o_collision;
  logic [6:0]        i_instr;
  logic [2:0]        i_i, o_dest;
  logic [DATA_W-1:0] i_sj;
  logic [RES_W-1:0]  o_result;

  scalar_bitcnt_unit #(
    .DATA_W(DATA_W), .RES_W(RES_W), .POP_LAT(POP_LAT), .LZ_LAT(LZ_LAT), .TZ_OPCODE(OP_TZ)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_instr(i_instr), .i_i(i_i), .i_sj(i_sj),
    .o_ready(o_ready), .o_valid(o_valid), .o_dest(o_dest), .o_result(o_result),
    .o_collision(o_collision)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  // exp_q entry: {retire cycle, dest, result}. A result issued in cycle c with latency L
  // is visible in cycle c+L; only one retirement may land in any cycle.
  logic [EW-1:0]    exp_q[$];
  int               cyc, coll_cyc, n_vec, n_bad;
  logic             exp_v, exp_c, exp_rdy, obs_rdy;
  logic [2:0]       exp_d;
  logic [RES_W-1:0] exp_r;

  function automatic bit is_recog(input logic [6:0] op);
    return (op == OP_POP) || (op == OP_LZ) || (TZ_EN && op == OP_TZ);
  endfunction

  function automatic int ref_count(input logic [6:0] op, input logic [DATA_W-1:0] v);
    int n;
    n = 0;
    if (op == OP_POP) begin
      for (int i = 0; i < DATA_W; i++) n += int'(v[i]);
      return n;
    end
    if (op == OP_LZ) begin
      for (int i = DATA_W - 1; i >= 0; i--) if (v[i]) return DATA_W - 1 - i;
      return DATA_W;
    end
    for (int i = 0; i < DATA_W; i++) if (v[i]) return i;
    return DATA_W;
  endfunction

  function automatic stim_t mk(input logic r, input logic v, input logic [6:0] op,
                               input logic [2:0] d, input logic [DATA_W-1:0] sj);
    stim_t s;
    s.r = r; s.v = v; s.op = op; s.d = d; s.sj = sj;
    return s;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle, records ready expectation, advances one clock and loads the next
  // cycle's expected outputs into exp_*.
  task automatic step(input stim_t st);
    int  lat, ec;
    bit  busy;
    rst = st.r; i_valid = st.v; i_instr = st.op; i_i = st.d; i_sj = st.sj;
    #1;
    lat  = (st.op == OP_POP) ? POP_LAT : LZ_LAT;
    busy = 1'b0;
    foreach (exp_q[k]) if (int'(exp_q[k][EW-1 -: 32]) == cyc + lat) busy = 1'b1;
    exp_rdy = !is_recog(st.op) || !busy;
    obs_rdy = o_ready;
    if (!st.r && st.v && is_recog(st.op)) begin
      if (busy) coll_cyc = cyc + 1;
      else exp_q.push_back({32'(cyc + lat), st.d, RES_W'(ref_count(st.op, st.sj))});
    end
    @(posedge clk);
    cyc++;
    if (st.r) begin
      exp_q.delete();
      coll_cyc = -1;
    end
    @(negedge clk);
    exp_v = 1'b0; exp_d = '0; exp_r = '0;
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      ec = int'(exp_q[k][EW-1 -: 32]);
      if (ec == cyc) begin
        exp_v = 1'b1;
        exp_d = exp_q[k][RES_W+2 -: 3];
        exp_r = exp_q[k][RES_W-1:0];
      end
      if (ec <= cyc) exp_q.delete(k);
    end
    exp_c = (coll_cyc == cyc);
  endtask

  function automatic stim_t idle();
    return mk(1'b0, 1'b0, 7'o000, 3'd0, '0);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_instr = OP_POP; i_i = '0; i_sj = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({o_valid, o_dest, o_result, o_collision} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%0b d=%0d r=%0d c=%0b exp all 0", o_valid, o_dest, o_result, o_collision);
    end
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_pop got=%0b exp=1", o_ready);
    end
    i_instr = OP_LZ;
    #1;
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_lz got=%0b exp=1", o_ready);
    end
    rst = 1'b0;
    cyc = 0; coll_cyc = -1;
    exp_q.delete();
  endtask

  task automatic run_seq(input string name, input stim_t s[$]);
    foreach (s[k]) begin
      step(s[k]);
      n_vec++;
      if (obs_rdy !== exp_rdy) begin
        n_bad++;
        $display("FAIL %s_ready cyc=%0d got=%0b exp=%0b", name, cyc - 1, obs_rdy, exp_rdy);
      end
      n_vec++;
      if ({o_valid, o_dest, o_result, o_collision} !== {exp_v, exp_d, exp_r, exp_c}) begin
        n_bad++;
        $display("FAIL %s_out cyc=%0d got v=%0b d=%0d r=%0d c=%0b exp v=%0b d=%0d r=%0d c=%0b",
                 name, cyc, o_valid, o_dest, o_result, o_collision, exp_v, exp_d, exp_r, exp_c);
      end
    end
  endtask

  task automatic test_pop();
    stim_t s[$];
    s.push_back(mk(0, 1, OP_POP, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF));
    s.push_back(mk(0, 1, OP_POP, 3'd1, 64'h0000_0000_0000_0001));
    s.push_back(mk(0, 1, OP_POP, 3'd7, 64'h8000_0000_0000_0000));
    s.push_back(mk(0, 1, OP_POP, 3'd2, '0));
    s.push_back(mk(0, 1, OP_POP, 3'd5, 64'hA5A5_0F0F_1234_5678));
    repeat (6) s.push_back(idle());
    run_seq("pop", s);
  endtask

  task automatic test_lz();
    stim_t s[$];
    s.push_back(mk(0, 1, OP_LZ, 3'd1, 64'h0000_0000_0001_0000));
    s.push_back(mk(0, 1, OP_LZ, 3'd2, 64'h0));
    s.push_back(mk(0, 1, OP_LZ, 3'd5, 64'h8000_0000_0000_0000));
    s.push_back(mk(0, 1, OP_LZ, 3'd6, 64'h0000_0000_0000_0001));
    s.push_back(mk(0, 1, OP_LZ, 3'd4, 64'h0000_00FF_0000_0000));
    repeat (5) s.push_back(idle());
    run_seq("lz", s);
  endtask

  task automatic test_conflict();
    stim_t s[$];
    s.push_back(mk(0, 1, OP_POP, 3'd0, 64'h0000_0000_0000_00FF));
    s.push_back(mk(0, 1, OP_LZ, 3'd1, 64'h0000_0000_0000_0100));
    repeat (6) s.push_back(idle());
    run_seq("conflict", s);
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    s.push_back(mk(0, 1, OP_LZ, 3'd1, 64'h0000_0000_0000_0F00));
    s.push_back(mk(0, 1, OP_POP, 3'd2, 64'h0000_0000_FFFF_0000));
    s.push_back(idle());
    s.push_back(mk(0, 1, OP_LZ, 3'd3, 64'h0001_0000_0000_0000));
    for (int k = 0; k < 4; k++) s.push_back(mk(0, 1, OP_POP, 3'(k), {$urandom, $urandom}));
    for (int k = 0; k < 4; k++) s.push_back(mk(0, 1, OP_LZ, 3'(k + 4), {$urandom, $urandom} >> (k * 9)));
    repeat (6) s.push_back(idle());
    run_seq("b2b", s);
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    s.push_back(mk(0, 1, OP_POP, 3'd6, 64'hFFFF_0000_FFFF_0000));
    s.push_back(idle());
    s.push_back(mk(1, 0, 7'o000, 3'd0, '0));
    repeat (6) s.push_back(idle());
    run_seq("rst_mid", s);
  endtask

  task automatic test_tz_and_unknown();
    stim_t s[$];
    s.push_back(mk(0, 1, OP_TZ, 3'd4, 64'h0000_0000_0000_0100));
    s.push_back(mk(0, 1, OP_TZ, 3'd5, 64'h0));
    s.push_back(mk(0, 1, 7'o000, 3'd7, 64'h1234));
    s.push_back(mk(0, 1, 7'o025, 3'd7, 64'hFFFF));
    repeat (5) s.push_back(idle());
    run_seq("tz_unk", s);
  endtask

  task automatic test_random();
    stim_t             s[$];
    logic [6:0]        op;
    logic [DATA_W-1:0] sj;
    int                sel;
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      op = OP_POP;
      else if (sel <= 6) op = OP_LZ;
      else if (sel <= 8) op = OP_TZ;
      else               op = 7'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0:       sj = {$urandom, $urandom};
        1:       sj = 64'h1 << $urandom_range(0, DATA_W - 1);
        2:       sj = '0;
        3:       sj = 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(0, DATA_W - 1);
        default: sj = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 59) == 0) s.push_back(mk(1, 0, 7'o000, 3'd0, '0));
      else s.push_back(mk(0, ($urandom_range(0, 9) < 7), op, 3'($urandom_range(0, 7)), sj));
    end
    repeat (8) s.push_back(idle());
    run_seq("random", s);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; coll_cyc = -1;
    exp_v = 0; exp_c = 0; exp_d = '0; exp_r = '0; exp_rdy = 1; obs_rdy = 1;
    test_reset();
    test_pop();
    test_lz();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_tz_and_unknown();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
